// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART serializer among NREQ packet requesters; optional lock timeout under UART_TX_SCHED_TIMEOUT_EN.
// Latency: byte accepted in S_IDLE -> tx_load next cycle; inside a packet, accept on first tx_busy=0 cycle, load one cycle later.
// Backpressure: req_ready only while idle or serializer free; tx_load never repeats until tx_busy has risen and fallen.
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int PTRW    = 2
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 256
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              tx_load,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              sched_busy
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    output logic              timeout_evt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_ACK, S_WAIT_FREE} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            tx_load_q, tx_load_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            lock_q, lock_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [PTRW-1:0] owner_q, owner_d;
    logic [NREQ-1:0] ready;
    logic [PTRW-1:0] win;
    logic [PTRW-1:0] scan_idx;
    logic            found;
    logic [7:0]      req_byte [NREQ];

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            evt_q, evt_d;
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    // Scan starts one past the last finished owner, so that owner has lowest priority.
    always_comb begin
        win      = ptr_q;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = PTRW'((int'(ptr_q) + i) % NREQ);
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tx_load_d = 1'b0;
        tx_data_d = tx_data_q;
        lock_d    = lock_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        ready     = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        evt_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    ready[win] = 1'b1;
                    tx_data_d  = req_byte[win];
                    grant_d    = NREQ'(1) << win;
                    owner_d    = win;
                    lock_d     = ~req_last[win];
                    tx_load_d  = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_FREE;
                end
            end
            S_WAIT_FREE: begin
                if (!tx_busy) begin
                    if (lock_q) begin
                        if (req_valid[owner_q]) begin
                            ready[owner_q] = 1'b1;
                            tx_data_d      = req_byte[owner_q];
                            lock_d         = ~req_last[owner_q];
                            tx_load_d      = 1'b1;
                            state_d        = S_LOAD;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                            cnt_d          = '0;
`endif
                        end else begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                            // Stalled owner: revoke the lock once the stall reaches TIMEOUT cycles.
                            if (cnt_q == CW'(TIMEOUT - 1)) begin
                                evt_d   = 1'b1;
                                lock_d  = 1'b0;
                                grant_d = '0;
                                ptr_d   = owner_q;
                                cnt_d   = '0;
                                state_d = S_IDLE;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
`endif
                        end
                    end else begin
                        ptr_d   = owner_q;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            tx_load_q <= 1'b0;
            tx_data_q <= 8'hFF;
            lock_q    <= 1'b0;
            ptr_q     <= PTRW'(NREQ - 1);
            owner_q   <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            evt_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tx_load_q <= tx_load_d;
            tx_data_q <= tx_data_d;
            lock_q    <= lock_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            cnt_q     <= cnt_d;
            evt_q     <= evt_d;
`endif
        end
    end

    assign req_ready  = rst ? '0 : ready;
    assign grant      = grant_q;
    assign tx_load    = tx_load_q;
    assign tx_data    = tx_data_q;
    assign sched_busy = (state_q != S_IDLE);
`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign timeout_evt = evt_q;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural serializer (busy for 6 cycles after each load).
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        sched_busy;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic        timeout_evt;
`endif

    always #5 clk = ~clk;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    uart_tx_sched #(.NREQ(4), .PTRW(2), .TIMEOUT(16)) dut (
`else
    uart_tx_sched #(.NREQ(4), .PTRW(2)) dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .sched_busy (sched_busy)
`ifdef UART_TX_SCHED_TIMEOUT_EN
        ,
        .timeout_evt(timeout_evt)
`endif
    );

    // Serializer model: busy rises the cycle after a load and stays high for 6 cycles.
    int ser_cnt;
    always @(posedge clk) begin
        if (rst)            ser_cnt <= 0;
        else if (tx_load)   ser_cnt <= 6;
        else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
    end
    assign tx_busy = (ser_cnt != 0);

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  src [4][$];
    int          cyc = 0;
    int          last_high = -1000;
    int          fall_cyc = -1;
    int          evt_cyc = -1;
    int          evt_n = 0;
    logic        prev_busy = 1'b0;
    logic [7:0]  loads [$];
    int          gaps [$];
    int          accs [$];
    logic [3:0]  s_ready, s_grant;
    logic        s_load, s_busy, s_sched;
    logic [7:0]  s_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < 4; i++) begin
            if (src[i].size() != 0) begin
                e = src[i][0];
                req_valid[i]       = 1'b1;
                req_last[i]        = e[8];
                req_data[i*8 +: 8] = e[7:0];
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    // Sample at the falling edge, then update requester queues just after the rising edge.
    task automatic tick();
        logic [3:0] acc;
        @(negedge clk);
        cyc++;
        s_ready = req_ready;
        s_grant = grant;
        s_load  = tx_load;
        s_data  = tx_data;
        s_busy  = tx_busy;
        s_sched = sched_busy;
        if (tx_busy) last_high = cyc;
        if (!tx_busy && prev_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
        acc = req_ready & req_valid;
        for (int i = 0; i < 4; i++) if (acc[i]) accs.push_back(i);
        if (tx_load) begin
            loads.push_back(tx_data);
            gaps.push_back(cyc - last_high);
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        if (timeout_evt) begin
            evt_cyc = cyc;
            evt_n++;
        end
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) void'(src[i].pop_front());
        drive();
    endtask

    task automatic clear_logs();
        loads.delete();
        gaps.delete();
        accs.delete();
        evt_cyc   = -1;
        evt_n     = 0;
        fall_cyc  = -1;
        last_high = -1000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) src[i].delete();
        drive();
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_acc(input int n, input string tag);
        int b = 0;
        while (accs.size() < n && b < 300) begin tick(); b++; end
        chk(tag, 32'(accs.size() >= n), 32'd1);
    endtask

    task automatic wait_loads(input int n, input string tag);
        int b = 0;
        while (loads.size() < n && b < 300) begin tick(); b++; end
        chk(tag, 32'(loads.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int b = 0;
        tick();
        while (s_sched && b < 300) begin tick(); b++; end
        chk(tag, 32'(s_sched), 32'd0);
    endtask

    function automatic logic [31:0] pack_loads();
        logic [31:0] p = '0;
        for (int i = 0; i < loads.size() && i < 4; i++) p = (p << 8) | 32'(loads[i]);
        return p;
    endfunction

    function automatic logic [31:0] pack_accs();
        logic [31:0] p = '0;
        for (int i = 0; i < accs.size() && i < 4; i++) p = (p << 8) | 32'(8'(accs[i]));
        return p;
    endfunction

    initial begin
        int n;
        int bad;
        logic pb;

        // Reset state, with req0 offering a byte during reset.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) src[i].delete();
        src[0].push_back({1'b1, 8'h77});
        drive();
        tick();
        tick();
        chk("rst_grant",   32'(s_grant), 32'h0);
        chk("rst_tx_load", 32'(s_load),  32'h0);
        chk("rst_tx_data", 32'(s_data),  32'hFF);
        chk("rst_sched",   32'(s_sched), 32'h0);
        chk("rst_ready",   32'(s_ready), 32'h0);
        do_reset();

        // 1: single-byte packet from req0.
        src[0].push_back({1'b1, 8'h55});
        drive();
        tick();
        chk("s1_ready", 32'(s_ready), 32'h1);
        tick();
        chk("s1_load",  32'(s_load),  32'h1);
        chk("s1_data",  32'(s_data),  32'h55);
        chk("s1_grant", 32'(s_grant), 32'h1);
        n = 0; bad = 0; pb = 1'b1;
        while (s_grant != 4'h0 && n < 100) begin
            if (s_grant != 4'h1) bad++;
            pb = s_busy;
            tick();
            n++;
        end
        chk("s1_grant_hold",  32'(bad),     32'd0);
        chk("s1_grant_clear", 32'(s_grant), 32'h0);
        chk("s1_busy_fell",   32'(pb),      32'h0);
        chk("s1_load_count",  32'(loads.size()), 32'd1);

        // 2: req0 and req2 together, then req1, then req0 again.
        do_reset();
        src[0].push_back({1'b1, 8'hA0});
        src[2].push_back({1'b1, 8'hA2});
        drive();
        wait_acc(2, "s2_acc2");
        src[1].push_back({1'b1, 8'hB1});
        drive();
        wait_acc(3, "s2_acc3");
        src[0].push_back({1'b1, 8'hB0});
        drive();
        wait_acc(4, "s2_acc4");
        wait_idle("s2_idle");
        chk("s2_order", pack_accs(),  32'h00020100);
        chk("s2_data",  pack_loads(), 32'hA0A2B1B0);

        // 3: three-byte packet from req1 while req3 waits.
        do_reset();
        src[1].push_back({1'b0, 8'hC1});
        src[1].push_back({1'b0, 8'hC2});
        src[1].push_back({1'b1, 8'hC3});
        src[3].push_back({1'b1, 8'hD3});
        drive();
        wait_loads(4, "s3_loads");
        wait_idle("s3_idle");
        chk("s3_data",  pack_loads(), 32'hC1C2C3D3);
        chk("s3_order", pack_accs(),  32'h01010103);
        chk("s3_gap2",  32'(gaps[1]), 32'd2);
        chk("s3_gap3",  32'(gaps[2]), 32'd2);

        // 4: reset while holding a packet in S_WAIT_FREE.
        do_reset();
        src[2].push_back({1'b0, 8'hE0});
        src[2].push_back({1'b0, 8'hE1});
        src[2].push_back({1'b1, 8'hE2});
        drive();
        wait_loads(1, "s4_first_load");
        tick(); tick(); tick();
        chk("s4_pre_busy", 32'(s_busy), 32'h1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) src[i].delete();
        drive();
        tick();
        tick();
        chk("s4_grant",   32'(s_grant), 32'h0);
        chk("s4_tx_load", 32'(s_load),  32'h0);
        chk("s4_tx_data", 32'(s_data),  32'hFF);
        chk("s4_sched",   32'(s_sched), 32'h0);
        rst = 1'b0;
        clear_logs();
        src[0].push_back({1'b1, 8'hF0});
        src[2].push_back({1'b1, 8'hF2});
        src[3].push_back({1'b1, 8'hF3});
        drive();
        tick();
        chk("s4_ready_req0", 32'(s_ready), 32'h1);
        wait_acc(3, "s4_acc3");
        wait_idle("s4_idle");
        chk("s4_order", pack_accs(), 32'h00000203);

        // 5/6: req2 stalls mid-packet while req3 waits.
        do_reset();
        src[2].push_back({1'b0, 8'h5A});
        src[3].push_back({1'b1, 8'h3C});
        drive();
        wait_loads(1, "s5_first_load");
        chk("s5_grant", 32'(s_grant), 32'h4);
`ifdef UART_TX_SCHED_TIMEOUT_EN
        n = 0;
        while (evt_cyc < 0 && n < 200) begin tick(); n++; end
        chk("s5_evt_seen",   32'(evt_cyc >= 0),      32'd1);
        chk("s5_evt_delay",  32'(evt_cyc - fall_cyc), 32'd16);
        chk("s5_grant_clr",  32'(s_grant),           32'h0);
        wait_loads(2, "s5_second_load");
        wait_idle("s5_idle");
        chk("s5_evt_pulses", 32'(evt_n),             32'd1);
        chk("s5_data",       pack_loads(),           32'h00005A3C);
        chk("s5_order",      pack_accs(),            32'h00000203);
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (s_grant != 4'h4) bad++;
        end
        chk("s6_grant_hold", 32'(bad),          32'd0);
        chk("s6_load_count", 32'(loads.size()), 32'd1);
        chk("s6_sched",      32'(s_sched),      32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
